// File: rtl/fp_to_int_if.sv
// fp_to_int_if: operand/result handshake bundle for fp_to_int_converter.
//   master: operand producer / result consumer (drives in_valid, float_in, rm,
//           is_signed, out_ready)
//   slave : converter (drives in_ready, out_valid, int_out, invalid, inexact)
// The parameters must match those of the converter instance it connects to.
interface fp_to_int_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   float_in;
  logic [1:0]             rm;
  logic                   is_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [INT_W-1:0]       int_out;
  logic                   invalid;
  logic                   inexact;

  modport master (
    output in_valid, float_in, rm, is_signed, out_ready,
    input  in_ready, out_valid, int_out, invalid, inexact
  );

  modport slave (
    input  in_valid, float_in, rm, is_signed, out_ready,
    output in_ready, out_valid, int_out, invalid, inexact
  );
endinterface

// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: IEEE-754 float to signed/unsigned INT_W-bit integer.
// One operation in flight: IDLE -> CLASSIFY -> ALIGN -> ROUND -> HOLD.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : fp_to_int_if.slave (operand in via in_valid/in_ready, result out
//           via out_valid/out_ready with int_out, invalid, inexact)
// Rounding modes (rm): 00 toward zero, 01 toward +inf, 10 toward -inf,
// 11 nearest-even. Out-of-range, NaN and Inf saturate and raise invalid.
module fp_to_int_converter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  fp_to_int_if.slave  bus
);

  localparam int FW    = EXP_W + MAN_W + 1;
  localparam int MAG_W = INT_W + 1;       // magnitude plus rounding carry
  localparam int EW    = EXP_W + 2;       // signed unbiased exponent
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLASSIFY, ALIGN, ROUND, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           op_q, op_d;
  logic [1:0]              rm_q, rm_d;
  logic                    sgn_q, sgn_d;     // signed result requested
  logic                    sign_q, sign_d;   // operand sign
  logic signed [EW-1:0]    e_q, e_d;
  logic [MAN_W:0]          sig_q, sig_d;
  logic                    nan_q, nan_d, inf_q, inf_d, ovf_q, ovf_d;
  logic [MAG_W-1:0]        mag_q, mag_d;
  logic                    g_q, g_d, s_q, s_d;
  logic [INT_W-1:0]        res_q, res_d;
  logic                    inv_q, inv_d, inx_q, inx_d;

  // ---- classify (from latched operand) ----
  logic [EXP_W-1:0]        exp_f;
  logic [MAN_W-1:0]        man_f;
  logic signed [EW-1:0]    cls_e;
  logic [MAN_W:0]          cls_sig;
  logic                    cls_nan, cls_inf, cls_ovf;

  always_comb begin
    exp_f   = op_q[FW-2:MAN_W];
    man_f   = op_q[MAN_W-1:0];
    cls_nan = 1'b0;
    cls_inf = 1'b0;
    cls_ovf = 1'b0;
    if (exp_f == '0) begin
      cls_sig = {1'b0, man_f};
      cls_e   = EW'(1 - BIAS);
    end else begin
      cls_sig = {1'b1, man_f};
      cls_e   = EW'(int'(exp_f) - BIAS);
    end
    if (&exp_f) begin
      cls_nan = |man_f;
      cls_inf = ~|man_f;
    end else begin
      // Too large for any INT_W result: no need to shift at all.
      cls_ovf = int'(cls_e) >= INT_W;
    end
  end

  // ---- align: integer magnitude plus guard/sticky ----
  // Right-shift amount sh = MAN_W - e covers both e<0 and 0<=e<=MAN_W:
  // guard is the bit at sh-1, sticky everything below it.
  int                      sh;
  logic [MAG_W-1:0]        al_mag;
  logic                    al_g, al_s;

  always_comb begin
    sh     = MAN_W - int'(e_q);
    al_mag = '0;
    al_g   = 1'b0;
    al_s   = 1'b0;
    if (sh >= 0) begin
      al_mag = MAG_W'(sig_q >> sh);
      for (int i = 0; i <= MAN_W; i++) begin
        if (i == sh - 1)     al_g = sig_q[i];
        else if (i < sh - 1) al_s = al_s | sig_q[i];
      end
    end else begin
      al_mag = MAG_W'(sig_q) << (-sh);
    end
  end

  // ---- round, range check, saturate ----
  logic                    inc;
  logic [MAG_W-1:0]        mag_r;
  logic                    in_range;

  always_comb begin
    case (rm_q)
      2'b00:   inc = 1'b0;
      2'b01:   inc = (g_q | s_q) & ~sign_q;
      2'b10:   inc = (g_q | s_q) & sign_q;
      default: inc = g_q & (s_q | mag_q[0]);
    endcase
    mag_r = mag_q + MAG_W'(inc);
    if (sgn_q) in_range = sign_q ? (mag_r <= NEG_LIM) : (mag_r <= POS_LIM);
    else       in_range = sign_q ? (mag_r == '0)     : ~mag_r[INT_W];
    rd_inv_calc();
  end

  logic [INT_W-1:0]        rd_res;
  logic                    rd_inv, rd_inx;

  function automatic void rd_inv_calc();
  endfunction

  always_comb begin
    rd_res = '0;
    rd_inv = 1'b0;
    rd_inx = 1'b0;
    if (nan_q) begin
      rd_inv = 1'b1;
      rd_res = sgn_q ? INT_MAX : '1;
    end else if (inf_q || ovf_q || !in_range) begin
      rd_inv = 1'b1;
      if (sign_q) rd_res = sgn_q ? INT_MIN : '0;
      else        rd_res = sgn_q ? INT_MAX : '1;
    end else begin
      rd_inx = g_q | s_q;
      rd_res = sign_q ? -mag_r[INT_W-1:0] : mag_r[INT_W-1:0];
    end
  end

  // ---- FSM next state / register loads ----
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rm_d    = rm_q;
    sgn_d   = sgn_q;
    sign_d  = sign_q;
    e_d     = e_q;
    sig_d   = sig_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    ovf_d   = ovf_q;
    mag_d   = mag_q;
    g_d     = g_q;
    s_d     = s_q;
    res_d   = res_q;
    inv_d   = inv_q;
    inx_d   = inx_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d    = bus.float_in;
        rm_d    = bus.rm;
        sgn_d   = bus.is_signed;
        state_d = CLASSIFY;
      end
      CLASSIFY: begin
        sign_d  = op_q[FW-1];
        e_d     = cls_e;
        sig_d   = cls_sig;
        nan_d   = cls_nan;
        inf_d   = cls_inf;
        ovf_d   = cls_ovf;
        state_d = ALIGN;
      end
      ALIGN: begin
        mag_d   = al_mag;
        g_d     = al_g;
        s_d     = al_s;
        state_d = ROUND;
      end
      ROUND: begin
        res_d   = rd_res;
        inv_d   = rd_inv;
        inx_d   = rd_inx;
        state_d = HOLD;
      end
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rm_q    <= '0;
      sgn_q   <= 1'b0;
      sign_q  <= 1'b0;
      e_q     <= '0;
      sig_q   <= '0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      mag_q   <= '0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      sgn_q   <= sgn_d;
      sign_q  <= sign_d;
      e_q     <= e_d;
      sig_q   <= sig_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      ovf_q   <= ovf_d;
      mag_q   <= mag_d;
      g_q     <= g_d;
      s_q     <= s_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      inx_q   <= inx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.int_out   = res_q;
  assign bus.invalid   = inv_q;
  assign bus.inexact   = inx_q;

endmodule
